iterative_muldiv: RTL and testbench

- Multi-cycle, parametrised multiply/divide unit for the RV32M extension; it sits beside the single-cycle ALU in the execute stage.
- Accepts one operation at a time through a valid/ready handshake. It iterates one bit per cycle: shift-add for multiply, restoring division for divide.
- Returns a WIDTH-bit result together with a passthrough tag (destination register), and can be flushed by the pipeline on redirect.

---
 rtl/iterative_muldiv.sv | 224 ++++++++++++++++++++++
 tb/tb_iterative_muldiv.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv.sv
// ----------------------------------------------------------------------------
// iterative_muldiv: multi-cycle RV32M multiply/divide unit.
//   One operation in flight at a time. Multiply is shift-add and divide is
//   restoring division, one bit per cycle on operand magnitudes. The sign
//   fix-up and result selection are combinational from the DONE registers.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous kill of any in-flight/completed operation
//   in_valid/in_ready   request handshake; in_op (funct3), in_a, in_b, in_tag
//   out_valid/out_ready result handshake; out_result, out_tag (0 when idle)
//   busy                high while an operation occupies the unit
// ----------------------------------------------------------------------------
module iterative_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // Multiply: {hi, lo} is the product register, lo starts as the multiplier.
    // Divide:   hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  m_q, m_d;      // multiplicand or divisor magnitude
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    // Special-case result already loaded: spend one cycle without iterating.
    logic              hold_q, hold_d;

    // Accept-time decode
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf;

    always_comb begin
        a_signed = (in_op == OpMulh) || (in_op == OpMulhsu) ||
                   (in_op == OpDiv)  || (in_op == OpRem);
        b_signed = (in_op == OpMulh) || (in_op == OpDiv) || (in_op == OpRem);
        a_neg    = a_signed & in_a[WIDTH-1];
        b_neg    = b_signed & in_b[WIDTH-1];
        a_mag    = a_neg ? -in_a : in_a;
        b_mag    = b_neg ? -in_b : in_b;
        div_zero = in_op[2] && (in_b == '0);
        div_ovf  = ((in_op == OpDiv) || (in_op == OpRem)) &&
                   (in_a == MinNeg) && (in_b == '1);
    end

    // One iteration step
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH + 1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        div_ge    = ~div_diff[WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        m_d       = m_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hold_d    = hold_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = in_op;
                    tag_d   = in_tag;
                    state_d = StCalc;
                    if (div_zero || div_ovf) begin
                        hold_d    = 1'b1;
                        cnt_d     = CntW'(1);
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        m_d       = '0;
                        hi_d      = div_zero ? in_a : '0;
                        lo_d      = div_zero ? '1 : in_a;
                    end else begin
                        hold_d    = 1'b0;
                        cnt_d     = CntW'(WIDTH);
                        neg_res_d = in_op[2] ? ((in_op == OpDiv) && (a_neg ^ b_neg))
                                             : (a_neg ^ b_neg);
                        neg_rem_d = (in_op == OpRem) && a_neg;
                        hi_d      = '0;
                        lo_d      = in_op[2] ? a_mag : b_mag;
                        m_d       = in_op[2] ? b_mag : a_mag;
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q - CntW'(1);
                if (!hold_q) begin
                    if (op_q[2]) begin
                        hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                end
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush overrides everything, including an accept in IDLE.
        if (flush) begin
            state_d = StIdle;
            if (state_q == StIdle) begin
                op_d      = op_q;
                tag_d     = tag_q;
                cnt_d     = cnt_q;
                hi_d      = hi_q;
                lo_d      = lo_q;
                m_d       = m_q;
                neg_res_d = neg_res_q;
                neg_rem_d = neg_rem_q;
                hold_d    = hold_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hold_q    <= hold_d;
        end
    end

    // Sign fix-up and result selection
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, result;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_res_q ? -prod : prod;
        quo_fix  = neg_res_q ? -lo_q : lo_q;
        rem_fix  = neg_rem_q ? -hi_q : hi_q;
        unique case (op_q)
            OpMul:                      result = prod_fix[WIDTH-1:0];
            OpMulh, OpMulhsu, OpMulhu:  result = prod_fix[2*WIDTH-1:WIDTH];
            OpDiv, OpDivu:              result = quo_fix;
            OpRem, OpRemu:              result = rem_fix;
            default:                    result = '0;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == StIdle);
        busy       = (state_q == StCalc) || (state_q == StDone);
        out_valid  = (state_q == StDone);
        out_result = out_valid ? result : '0;
        out_tag    = out_valid ? tag_q : '0;
    end

endmodule

// File: tb/tb_iterative_muldiv.sv
module tb_iterative_muldiv;

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    iterative_muldiv #(
        .WIDTH(32),
        .TAG_W(5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request; returns #1 after the accept edge with operands scrambled.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h1234_5678;
        in_tag   = 5'h1F;
    endtask

    // Cycles from the accept edge until out_valid is seen (bounded at 100).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res,
                          output logic [4:0] otag, output int lat);
        start_op(op, a, b, tag);
        wait_valid(lat);
        res  = out_result;
        otag = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b expected 1 0 0",
                     in_ready, out_valid, busy);
        end
        tests_run++;
        if (out_result !== 32'h0 || out_tag !== 5'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got res=%h tag=%h expected 0 0", out_result, out_tag);
        end
    endtask

    task automatic test_mul();
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        run_op(OpMul, 32'd7, 32'hFFFF_FFFD, 5'h13, res, tag, lat);
        tests_run++;
        if (res !== 32'hFFFF_FFEB) begin
            tests_failed++;
            $display("FAIL mul_result: got %h expected ffffffeb", res);
        end
        tests_run++;
        if (lat !== 32) begin
            tests_failed++;
            $display("FAIL mul_latency: got %0d expected 32", lat);
        end
        tests_run++;
        if (tag !== 5'h13) begin
            tests_failed++;
            $display("FAIL mul_tag: got %h expected 13", tag);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  ops [3] = '{OpMulh, OpMulhu, OpMulhsu};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 2), res, tag, lat);
            tests_run++;
            if (res !== exp[i] || lat !== 32) begin
                tests_failed++;
                $display("FAIL mulh[%0d]: got %h lat %0d expected %h lat 32",
                         i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [6] = '{OpDiv, OpRem, OpDivu, OpRemu, OpDiv, OpRem};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFD, 32'd1};
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 8), res, tag, lat);
            tests_run++;
            if (res !== exp[i] || lat !== 32 || tag !== 5'(i + 8)) begin
                tests_failed++;
                $display("FAIL div[%0d]: got %h lat %0d tag %h expected %h lat 32 tag %h",
                         i, res, lat, tag, exp[i], 5'(i + 8));
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{OpDiv, OpRemu, OpDiv, OpRem};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 20), res, tag, lat);
            tests_run++;
            if (res !== exp[i] || lat !== 1) begin
                tests_failed++;
                $display("FAIL special[%0d]: got %h lat %0d expected %h lat 1",
                         i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        start_op(OpDivu, 32'd100, 32'd7, 5'h0A);
        wait_valid(lat);
        tests_run++;
        if (lat !== 32) begin
            tests_failed++;
            $display("FAIL bp_latency: got %0d expected 32", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_result !== 32'd14 || out_tag !== 5'h0A ||
                in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got vld=%b res=%h tag=%h rdy=%b expected 1 0000000e 0a 0",
                         i, out_valid, out_result, out_tag, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        start_op(OpMul, 32'd3, 32'd4, 5'h01);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_next_accept: got busy=%b expected 1", busy);
        end
        wait_valid(lat);
        tests_run++;
        if (out_result !== 32'd12 || lat !== 32) begin
            tests_failed++;
            $display("FAIL bp_next_result: got %h lat %0d expected 0000000c lat 32",
                     out_result, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        bit          seen;
        start_op(OpMul, 32'd9, 32'd9, 5'h04);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_calc: got busy=%b rdy=%b expected 0 1", busy, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_valid: got out_valid seen=%b expected 0", seen);
        end
        // flush together with in_valid in IDLE must not accept
        in_op    = OpMul;
        in_a     = 32'd2;
        in_b     = 32'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle: got busy=%b expected 0", busy);
        end
        run_op(OpMulhu, 32'd3, 32'd5, 5'h03, res, tag, lat);
        tests_run++;
        if (res !== 32'd0 || lat !== 32 || tag !== 5'h03) begin
            tests_failed++;
            $display("FAIL flush_after: got %h lat %0d tag %h expected 0 lat 32 tag 03",
                     res, lat, tag);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        start_op(OpMulh, 32'd11, 32'd13, 5'h06);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_calc: got vld=%b rdy=%b busy=%b expected 0 1 0",
                     out_valid, in_ready, busy);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start_op(OpMul, 32'd7, 32'd3, 5'h09);
        wait_valid(lat);
        tests_run++;
        if (out_result !== 32'd21 || out_tag !== 5'h09) begin
            tests_failed++;
            $display("FAIL areset_pre: got %h tag %h expected 00000015 tag 09",
                     out_result, out_tag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'h0) begin
            tests_failed++;
            $display("FAIL areset_done: got vld=%b res=%h tag=%h expected 0 0 0",
                     out_valid, out_result, out_tag);
        end
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_a      = 32'h0;
        in_b      = 32'h0;
        in_tag    = 5'h0;
        out_ready = 1'b1;
        #1;
        test_reset();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
